// File: rtl/crc_rx_pkg.sv
// rtl/crc_rx_pkg.sv - shared FSM state enum and default CRC constants for the serial CRC checker
package crc_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CRC  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int         DEF_CRC_W = 8;
    localparam logic [7:0] DEF_POLY  = 8'hE0;
    localparam logic [7:0] DEF_SEED  = 8'hFF;

endpackage

// File: rtl/lfsr_crc_checker_if.sv
// rtl/lfsr_crc_checker_if.sv - serial receive line and frame result signals of the CRC checker
interface lfsr_crc_checker_if;

    logic rx_bit;
    logic rx_data_en;
    logic rx_crc_en;
    logic busy;
    logic crc_done;
    logic crc_err;

    modport master (
        output rx_bit, rx_data_en, rx_crc_en,
        input  busy, crc_done, crc_err
    );

    modport slave (
        input  rx_bit, rx_data_en, rx_crc_en,
        output busy, crc_done, crc_err
    );

endinterface

// File: rtl/crc_bit_counter.sv
// rtl/crc_bit_counter.sv - saturating up-counter with enable, synchronous clear and terminal-count stop
module crc_bit_counter #(
    parameter int MAX = 8,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         stop
);

    logic [W-1:0] cnt_q, cnt_d;

    assign stop = (cnt_q == W'(MAX));
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !stop) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lfsr_crc_checker.sv
// rtl/lfsr_crc_checker.sv - serial frame receiver: reflected LFSR over data bits, LSB-first CRC compare
module lfsr_crc_checker
    import crc_rx_pkg::*;
#(
    parameter int               CRC_W    = DEF_CRC_W,
    parameter logic [CRC_W-1:0] POLY     = CRC_W'(DEF_POLY),
    parameter logic [CRC_W-1:0] SEED     = CRC_W'(DEF_SEED),
    parameter int               MAX_DATA = 64
) (
    input  logic               clk,
    input  logic               rst,
    lfsr_crc_checker_if.slave  bus
);

    localparam int DW = $clog2(MAX_DATA + 1);
    localparam int CW = $clog2(CRC_W + 1);

    state_e           state_q, state_d;
    logic [CRC_W-1:0] lfsr_q, lfsr_d;
    logic [CRC_W-1:0] lfsr_upd, lfsr_sh;
    logic [DW-1:0]    data_cnt_q, data_cnt_d;
    logic             mismatch_q, mismatch_d;
    logic             overflow_q, overflow_d;
    logic [CW-1:0]    crc_cnt;
    logic             crc_stop;
    logic             crc_clr;
    logic             crc_en;

    always_comb begin
        lfsr_upd = (lfsr_q >> 1) ^ ((bus.rx_bit ^ lfsr_q[0]) ? POLY : '0);
        lfsr_sh  = lfsr_q >> crc_cnt;
    end

    // Counter is held at zero outside CRC so it starts fresh on every entry.
    assign crc_clr = (state_q != ST_CRC);
    assign crc_en  = (state_q == ST_CRC) && bus.rx_crc_en;

    crc_bit_counter #(
        .MAX (CRC_W),
        .W   (CW)
    ) u_crc_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (crc_clr),
        .en   (crc_en),
        .cnt  (crc_cnt),
        .stop (crc_stop)
    );

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        data_cnt_d = data_cnt_q;
        mismatch_d = mismatch_q;
        overflow_d = overflow_q;
        case (state_q)
            ST_IDLE: begin
                lfsr_d     = SEED;
                data_cnt_d = '0;
                mismatch_d = 1'b0;
                overflow_d = 1'b0;
                if (bus.rx_data_en) begin
                    lfsr_d     = lfsr_upd;
                    data_cnt_d = DW'(1);
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.rx_data_en) begin
                    lfsr_d = lfsr_upd;
                    if (data_cnt_q == DW'(MAX_DATA)) begin
                        overflow_d = 1'b1;
                    end else begin
                        data_cnt_d = data_cnt_q + DW'(1);
                    end
                end else begin
                    state_d = ST_CRC;
                end
            end
            ST_CRC: begin
                if (crc_en && !crc_stop) begin
                    if (bus.rx_bit != lfsr_sh[0]) begin
                        mismatch_d = 1'b1;
                    end
                    if (crc_cnt == CW'(CRC_W - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                lfsr_d     = SEED;
                data_cnt_d = '0;
                mismatch_d = 1'b0;
                overflow_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            lfsr_q     <= SEED;
            data_cnt_q <= '0;
            mismatch_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            data_cnt_q <= data_cnt_d;
            mismatch_q <= mismatch_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.crc_done = (state_q == ST_DONE);
    assign bus.crc_err  = (state_q == ST_DONE) && (mismatch_q || overflow_q);

endmodule

// File: tb/tb_lfsr_crc_checker.sv
// tb/tb_lfsr_crc_checker.sv - scoreboard bench for lfsr_crc_checker with directed frames
module tb_lfsr_crc_checker;

    typedef struct {
        logic err;
        int   start;
        int   lat;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];

    lfsr_crc_checker_if bus();

    lfsr_crc_checker #(
        .CRC_W    (8),
        .POLY     (8'hE0),
        .SEED     (8'h00),
        .MAX_DATA (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rx_bit     = 1'b0;
        bus.rx_data_en = 1'b0;
        bus.rx_crc_en  = 1'b0;
    endtask

    // Latency from first data bit driven to crc_done seen: n data + 1 gap + 8 crc + waits.
    task automatic frame(input int n, input logic [127:0] d, input logic [7:0] crc,
                         input int wait_at, input int nwait, input logic noise,
                         input logic exp_err);
        exp_t e;
        e.err   = exp_err;
        e.start = cyc;
        e.lat   = n + 9 + ((wait_at >= 0) ? nwait : 0);
        sb.push_back(e);
        for (int i = 0; i < n; i++) begin
            bus.rx_data_en = 1'b1;
            bus.rx_crc_en  = 1'b0;
            bus.rx_bit     = d[i];
            tick();
        end
        idle_inputs();
        tick();
        for (int k = 0; k < 8; k++) begin
            if (k == wait_at) begin
                for (int w = 0; w < nwait; w++) begin
                    bus.rx_crc_en  = 1'b0;
                    bus.rx_data_en = noise;
                    bus.rx_bit     = 1'b1;
                    tick();
                end
            end
            bus.rx_crc_en  = 1'b1;
            bus.rx_data_en = noise;
            bus.rx_bit     = crc[k];
            tick();
        end
        idle_inputs();
        tick();
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && bus.crc_done) begin
            if (sb.size() == 0) begin
                check("unexpected_crc_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("crc_err", int'(bus.crc_err), int'(e.err));
                check("done_latency", cyc - e.start, e.lat);
            end
        end
    end

    initial begin
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.crc_done), 0);
        check("reset_err", int'(bus.crc_err), 0);
        rst = 1'b1;

        // one data bit 1 from seed 0 gives lfsr 8'hE0
        frame(1, 128'h1, 8'hE0, -1, 0, 1'b0, 1'b0);
        frame(1, 128'h1, 8'h60, -1, 0, 1'b0, 1'b1);
        frame(8, 128'h0, 8'h00, -1, 0, 1'b0, 1'b0);
        frame(8, 128'h0, 8'h00, 4, 3, 1'b0, 1'b0);
        frame(64, 128'h0, 8'h00, -1, 0, 1'b0, 1'b0);
        frame(65, 128'h0, 8'h00, -1, 0, 1'b0, 1'b1);

        // abort mid-CRC with reset
        bus.rx_data_en = 1'b1;
        bus.rx_bit     = 1'b1;
        tick();
        idle_inputs();
        tick();
        for (int k = 0; k < 4; k++) begin
            bus.rx_crc_en = 1'b1;
            bus.rx_bit    = 1'b0;
            tick();
        end
        idle_inputs();
        check("busy_mid_frame", int'(bus.busy), 1);
        rst = 1'b0;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.crc_done), 0);
        check("abort_err", int'(bus.crc_err), 0);
        tick();
        tick();
        rst = 1'b1;
        frame(1, 128'h1, 8'hE0, -1, 0, 1'b0, 1'b0);

        // rx_crc_en in IDLE is ignored
        bus.rx_crc_en = 1'b1;
        bus.rx_bit    = 1'b1;
        tick();
        tick();
        idle_inputs();
        check("idle_crc_en_busy", int'(bus.busy), 0);
        tick();
        check("idle_crc_en_busy_after", int'(bus.busy), 0);

        // data_en noise during CRC, then back-to-back frame: bits 1,1 give 8'h90
        frame(1, 128'h1, 8'hE0, 2, 2, 1'b1, 1'b0);
        frame(2, 128'h3, 8'h90, -1, 0, 1'b0, 1'b0);
        frame(2, 128'h3, 8'h91, -1, 0, 1'b0, 1'b1);

        for (int i = 0; i < 50 && sb.size() > 0; i++) begin
            tick();
        end
        check("pending_frames", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
